// File: rtl/seq_gen.sv
// Registered 2-bit symbol stream source: repeats a programmable pattern with filler gaps between repetitions.
// Build option SEQ_GEN_LFSR_FILL_EN replaces the constant filler with the low bits of a 4-bit LFSR.
module seq_gen #(
  parameter int         PAT_LEN  = 4,
  parameter int         REP_W    = 4,
  parameter int         GAP_W    = 4,
  parameter logic [1:0] FILL_SYM = 2'b00
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [2*PAT_LEN-1:0]   pattern,
  input  logic [REP_W-1:0]       rep,
  input  logic [GAP_W-1:0]       gap,
  output logic [1:0]             out,
  output logic                   out_valid,
  output logic                   busy,
  output logic                   done
);

  localparam int IDX_W = $clog2(PAT_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GAP  = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [2*PAT_LEN-1:0] pat_q, pat_d;
  logic [REP_W-1:0]     rep_q, rep_d;
  logic [GAP_W-1:0]     gap_cap_q, gap_cap_d;
  logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [1:0]           out_q, out_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 accept;
  logic [1:0]           fill_sym;
  logic [1:0]           sym [PAT_LEN];

`ifdef SEQ_GEN_LFSR_FILL_EN
  localparam logic [3:0] LFSR_SEED = 4'b1001;
  logic [3:0] lfsr_q, lfsr_d, lfsr_src;

  // Fibonacci form of x^4 + x^3 + 1
  function automatic logic [3:0] lfsr_step(input logic [3:0] s);
    return {s[2:0], s[3] ^ s[2]};
  endfunction

  // A burst always starts from the seed, even though the register may still hold a stale value.
  assign lfsr_src = (state_q == S_IDLE) ? LFSR_SEED : lfsr_q;
  assign fill_sym = lfsr_src[1:0];
`else
  assign fill_sym = FILL_SYM;
`endif

  assign accept    = (state_q == S_IDLE) && start && !abort;
  assign pat_d     = accept ? pattern : pat_q;
  assign gap_cap_d = accept ? gap : gap_cap_q;

  // Symbol k sits MSB-first; decoding from pat_d lets the very first symbol come straight off the input.
  genvar gi;
  generate
    for (gi = 0; gi < PAT_LEN; gi++) begin : g_sym
      assign sym[gi] = pat_d[2*(PAT_LEN-1-gi) +: 2];
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    rep_d       = rep_q;
    gap_cnt_d   = gap_cnt_q;
    idx_d       = idx_q;
    out_d       = 2'b00;
    out_valid_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
`ifdef SEQ_GEN_LFSR_FILL_EN
    lfsr_d      = accept ? LFSR_SEED : lfsr_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          rep_d     = rep;
          gap_cnt_d = GAP_W'(1);
          idx_d     = '0;
          if (rep == '0) begin
            state_d = S_DONE;
          end else if (gap != '0) begin
            state_d = S_GAP;
          end else begin
            state_d = S_SEND;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q == gap_cap_q) begin
          state_d = S_SEND;
          idx_d   = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      S_SEND: begin
        if (idx_q == LAST_IDX) begin
          rep_d = (rep_q != '0) ? rep_q - REP_W'(1) : '0;
          if (rep_q > REP_W'(1)) begin
            idx_d = '0;
            if (gap_cap_q != '0) begin
              state_d   = S_GAP;
              gap_cnt_d = GAP_W'(1);
            end else begin
              state_d = S_SEND;
            end
          end else begin
            state_d = S_DONE;
          end
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end

    // Outputs are a function of the state being entered, so they appear registered one edge later.
    case (state_d)
      S_GAP: begin
        out_d       = fill_sym;
        out_valid_d = 1'b1;
        busy_d      = 1'b1;
`ifdef SEQ_GEN_LFSR_FILL_EN
        lfsr_d      = lfsr_step(lfsr_src);
`endif
      end
      S_SEND: begin
        out_d       = sym[idx_d];
        out_valid_d = 1'b1;
        busy_d      = 1'b1;
      end
      S_DONE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: begin
        out_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      pat_q       <= '0;
      rep_q       <= '0;
      gap_cap_q   <= '0;
      gap_cnt_q   <= '0;
      idx_q       <= '0;
      out_q       <= 2'b00;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef SEQ_GEN_LFSR_FILL_EN
      lfsr_q      <= LFSR_SEED;
`endif
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      rep_q       <= rep_d;
      gap_cap_q   <= gap_cap_d;
      gap_cnt_q   <= gap_cnt_d;
      idx_q       <= idx_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef SEQ_GEN_LFSR_FILL_EN
      lfsr_q      <= lfsr_d;
`endif
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_seq_gen.sv
// Self-checking bench for seq_gen: directed scenarios plus randomized bursts against a cycle-list model.
module tb_seq_gen;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       abort;
  logic [7:0] pattern;
  logic [3:0] rep;
  logic [3:0] gap;
  logic [1:0] out;
  logic       out_valid;
  logic       busy;
  logic       done;

  int tests = 0;
  int fails = 0;
  int burst_no = 0;

  seq_gen #(
    .PAT_LEN (4),
    .REP_W   (4),
    .GAP_W   (4),
    .FILL_SYM(2'b00)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .abort    (abort),
    .pattern  (pattern),
    .rep      (rep),
    .gap      (gap),
    .out      (out),
    .out_valid(out_valid),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Observed vector is {done, busy, out_valid, out[1:0]}.
  task automatic check(input string tag, input logic [4:0] exp);
    logic [4:0] act;
    act = {done, busy, out_valid, out};
    tests++;
    assert (act === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b (done,busy,valid,out)", tag, act, exp);
    end
  endtask

  function automatic int burst_len(input int r, input int g);
    return (r == 0) ? 1 : r * (g + 4) + 1;
  endfunction

  // Caller is at a negedge. Burst expectations come from the written rules: per repetition,
  // g filler cycles then the four symbols MSB-first, then one done cycle, then idle.
  task automatic run_burst(input logic [7:0] p, input logic [3:0] r, input logic [3:0] g,
                           input int abort_at, input int restart_at);
    logic [4:0] exp_q[$];
    logic [1:0] s;
`ifdef SEQ_GEN_LFSR_FILL_EN
    int lf;
    lf = 9;
`endif
    for (int k = 0; k < int'(r); k++) begin
      for (int j = 0; j < int'(g); j++) begin
`ifdef SEQ_GEN_LFSR_FILL_EN
        exp_q.push_back({3'b011, 2'(lf % 4)});
        lf = ((lf * 2) % 16) + (((lf / 8) + (lf / 4)) % 2);
`else
        exp_q.push_back(5'b01100);
`endif
      end
      for (int n = 0; n < 4; n++) begin
        s = p[7 - 2*n -: 2];
        exp_q.push_back({3'b011, s});
      end
    end
    exp_q.push_back(5'b11000);
    if (abort_at > 0) begin
      while (exp_q.size() > abort_at) void'(exp_q.pop_back());
    end

    burst_no++;
    $display("[TB] burst %0d: pattern=%b rep=%0d gap=%0d abort_at=%0d restart_at=%0d",
             burst_no, p, r, g, abort_at, restart_at);
    pattern = p;
    rep     = r;
    gap     = g;
    start   = 1'b1;
    for (int c = 1; c <= exp_q.size() + 1; c++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      if (c <= exp_q.size()) check($sformatf("b%0d_cyc%0d", burst_no, c), exp_q[c-1]);
      else                   check($sformatf("b%0d_idle", burst_no), 5'b00000);
      if (c == abort_at) abort = 1'b1;
      if (c == restart_at) begin
        start   = 1'b1;
        pattern = 8'hFF;
        rep     = 4'd2;
        gap     = 4'd1;
      end
    end
  endtask

  initial begin
    int r, g, len, mode, ab, rs;
    reset_n = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    pattern = 8'h00;
    rep     = 4'd0;
    gap     = 4'd0;
    #1;
    check("reset_state", 5'b00000);
    @(negedge clk);
    @(negedge clk);
    check("reset_held", 5'b00000);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", 5'b00000);

    run_burst(8'b10_00_01_11, 4'd1, 4'd0, 0, 0);
    run_burst(8'b10_00_01_11, 4'd2, 4'd2, 0, 0);
    run_burst(8'b10_00_01_11, 4'd0, 4'd5, 0, 0);
    run_burst(8'b11_01_10_00, 4'd3, 4'd0, 6, 0);
    run_burst(8'b01_10_11_00, 4'd1, 4'd0, 0, 0);
    run_burst(8'b10_00_01_11, 4'd1, 4'd0, 0, 3);
    run_burst(8'b00_11_10_01, 4'd2, 4'd1, 0, 5);

    $display("[TB] start+abort together in IDLE");
    pattern = 8'hA5; rep = 4'd1; gap = 4'd0;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle_1", 5'b00000);
    @(negedge clk);
    check("start_abort_idle_2", 5'b00000);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_in_idle", 5'b00000);

    $display("[TB] async reset mid-SEND");
    pattern = 8'b01_11_00_10; rep = 4'd2; gap = 4'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("pre_reset_sym0", 5'b01101);
    @(negedge clk);
    check("pre_reset_sym1", 5'b01111);
    #2 reset_n = 1'b0;
    #1 check("async_reset_immediate", 5'b00000);
    @(negedge clk);
    check("async_reset_held", 5'b00000);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("post_reset_idle%0d", i), 5'b00000);
    end

    for (int t = 0; t < 25; t++) begin
      r    = $urandom_range(0, 3);
      g    = $urandom_range(0, 3);
      len  = burst_len(r, g);
      mode = $urandom_range(0, 3);
      ab   = (mode == 0) ? $urandom_range(1, len) : 0;
      rs   = (mode == 1) ? $urandom_range(1, len) : 0;
      run_burst(8'($urandom), 4'(r), 4'(g), ab, rs);
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        check($sformatf("rand_idle_gap%0d", t), 5'b00000);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
